// File: rtl/mem_stage_if.sv
// Signals of the memory stage: EX input bundle, WB output bundle, SRAM-like data bus
// and ID hazard hints. The master modport is the stage and the slave modport is its environment.
interface mem_stage_if #(
  parameter int unsigned SideW = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      ex_pc;
  logic [31:0]      ex_alu_result;
  logic [31:0]      ex_wdata;
  logic [7:0]       ex_mem_op;
  logic             ex_gr_we;
  logic             ex_res_from_mem;
  logic             ex_ertn;
  logic             ex_has_exception;
  logic [4:0]       ex_dest;
  logic [5:0]       ex_ecode;
  logic [8:0]       ex_esubcode;
  logic [SideW-1:0] ex_side;
  logic             flush;

  logic             data_req;
  logic             data_wr;
  logic [1:0]       data_size;
  logic [3:0]       data_wstrb;
  logic [31:0]      data_addr;
  logic [31:0]      data_wdata;
  logic             data_addr_ok;
  logic             data_data_ok;
  logic [31:0]      data_rdata;

  logic             out_valid;
  logic             out_ready;
  logic [31:0]      wb_pc;
  logic [31:0]      wb_alu_result;
  logic [31:0]      wb_rdata;
  logic [31:0]      wb_maddr;
  logic [7:0]       wb_mem_op;
  logic             wb_gr_we;
  logic             wb_res_from_mem;
  logic             wb_ertn;
  logic             wb_has_exception;
  logic [4:0]       wb_dest;
  logic [5:0]       wb_ecode;
  logic [8:0]       wb_esubcode;
  logic [SideW-1:0] wb_side;

  logic [4:0]       ms_dest;
  logic             ms_gr_we;
  logic             ms_load_pending;

  modport master (
    input  in_valid, ex_pc, ex_alu_result, ex_wdata, ex_mem_op, ex_gr_we, ex_res_from_mem,
           ex_ertn, ex_has_exception, ex_dest, ex_ecode, ex_esubcode, ex_side, flush,
           data_addr_ok, data_data_ok, data_rdata, out_ready,
    output in_ready, data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
           out_valid, wb_pc, wb_alu_result, wb_rdata, wb_maddr, wb_mem_op, wb_gr_we,
           wb_res_from_mem, wb_ertn, wb_has_exception, wb_dest, wb_ecode, wb_esubcode,
           wb_side, ms_dest, ms_gr_we, ms_load_pending
  );

  modport slave (
    output in_valid, ex_pc, ex_alu_result, ex_wdata, ex_mem_op, ex_gr_we, ex_res_from_mem,
           ex_ertn, ex_has_exception, ex_dest, ex_ecode, ex_esubcode, ex_side, flush,
           data_addr_ok, data_data_ok, data_rdata, out_ready,
    input  in_ready, data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
           out_valid, wb_pc, wb_alu_result, wb_rdata, wb_maddr, wb_mem_op, wb_gr_we,
           wb_res_from_mem, wb_ertn, wb_has_exception, wb_dest, wb_ecode, wb_esubcode,
           wb_side, ms_dest, ms_gr_we, ms_load_pending
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds one instruction, issues at most one data-bus
// transaction for it, flags misaligned accesses and hands the result to write-back.
module mem_stage #(
  parameter int unsigned SideW = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  mem_stage_if.master bus
);
  typedef enum logic [2:0] {StIdle, StReq, StWait, StDone, StDropReq, StDropWait} state_e;

  state_e           state_q;
  logic [31:0]      pc_q, alu_q, rdata_q, maddr_q, wdata_q;
  logic [7:0]       mem_op_q;
  logic             gr_we_q, res_from_mem_q, ertn_q, exc_q, wr_q;
  logic [4:0]       dest_q;
  logic [5:0]       ecode_q;
  logic [8:0]       esub_q;
  logic [SideW-1:0] side_q;
  logic [1:0]       size_q;
  logic [3:0]       wstrb_q;

  logic [7:0]  op;
  logic [1:0]  a;
  logic        in_ready, accept, ale, ale_own, exc_d, req_d;
  logic [1:0]  size_d;
  logic [3:0]  wstrb_d;
  logic [31:0] wdata_d;

  assign op       = bus.ex_mem_op;
  assign a        = bus.ex_alu_result[1:0];
  assign in_ready = (state_q == StIdle) | ((state_q == StDone) & bus.out_ready);
  assign accept   = bus.in_valid & in_ready & ~bus.flush;

  always_comb begin
    ale     = ((op[1] | op[4] | op[6]) & a[0]) | ((op[2] | op[7]) & (a != 2'b00));
    // An exception raised upstream keeps its own code; ALE only reports when it is first.
    ale_own = ale & ~bus.ex_has_exception;
    exc_d   = bus.ex_has_exception | ale;
    req_d   = (|op) & ~exc_d & ~bus.ex_ertn;
    size_d  = 2'd2;
    wstrb_d = 4'b0000;
    wdata_d = 32'h0;
    if (op[0] | op[3] | op[5]) begin
      size_d = 2'd0;
    end else if (op[1] | op[4] | op[6]) begin
      size_d = 2'd1;
    end
    if (op[5]) begin
      wstrb_d = 4'b0001 << a;
      wdata_d = {4{bus.ex_wdata[7:0]}};
    end else if (op[6]) begin
      wstrb_d = a[1] ? 4'b1100 : 4'b0011;
      wdata_d = {2{bus.ex_wdata[15:0]}};
    end else if (op[7]) begin
      wstrb_d = 4'b1111;
      wdata_d = bus.ex_wdata;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= StIdle;
      pc_q           <= '0;
      alu_q          <= '0;
      rdata_q        <= '0;
      maddr_q        <= '0;
      wdata_q        <= '0;
      mem_op_q       <= '0;
      gr_we_q        <= 1'b0;
      res_from_mem_q <= 1'b0;
      ertn_q         <= 1'b0;
      exc_q          <= 1'b0;
      wr_q           <= 1'b0;
      dest_q         <= '0;
      ecode_q        <= '0;
      esub_q         <= '0;
      side_q         <= '0;
      size_q         <= '0;
      wstrb_q        <= '0;
    end else if (accept) begin
      state_q        <= req_d ? StReq : StDone;
      pc_q           <= bus.ex_pc;
      alu_q          <= bus.ex_alu_result;
      rdata_q        <= '0;
      maddr_q        <= ale_own ? bus.ex_alu_result : 32'h0;
      wdata_q        <= wdata_d;
      mem_op_q       <= op;
      gr_we_q        <= bus.ex_gr_we;
      res_from_mem_q <= bus.ex_res_from_mem;
      ertn_q         <= bus.ex_ertn;
      exc_q          <= exc_d;
      wr_q           <= |op[7:5];
      dest_q         <= bus.ex_dest;
      ecode_q        <= ale_own ? 6'h09 : bus.ex_ecode;
      esub_q         <= ale_own ? 9'h0 : bus.ex_esubcode;
      side_q         <= bus.ex_side;
      size_q         <= size_d;
      wstrb_q        <= wstrb_d;
    end else begin
      unique case (state_q)
        StIdle: state_q <= StIdle;
        StReq: begin
          // A raised request is never withdrawn; a flush only marks the response as dead.
          if (bus.flush) begin
            state_q <= bus.data_addr_ok ? StDropWait : StDropReq;
          end else if (bus.data_addr_ok) begin
            state_q <= StWait;
          end
        end
        StWait: begin
          if (bus.flush) begin
            state_q <= bus.data_data_ok ? StIdle : StDropWait;
          end else if (bus.data_data_ok) begin
            state_q <= StDone;
            if (|mem_op_q[4:0]) rdata_q <= bus.data_rdata;
          end
        end
        StDone:     if (bus.flush || bus.out_ready) state_q <= StIdle;
        StDropReq:  if (bus.data_addr_ok) state_q <= StDropWait;
        StDropWait: if (bus.data_data_ok) state_q <= StIdle;
        default:    state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready         = in_ready;
  assign bus.out_valid        = (state_q == StDone) & ~bus.flush;
  assign bus.data_req         = (state_q == StReq) | (state_q == StDropReq);
  assign bus.data_wr          = wr_q;
  assign bus.data_size        = size_q;
  assign bus.data_wstrb       = wstrb_q;
  assign bus.data_addr        = alu_q;
  assign bus.data_wdata       = wdata_q;
  assign bus.wb_pc            = pc_q;
  assign bus.wb_alu_result    = alu_q;
  assign bus.wb_rdata         = rdata_q;
  assign bus.wb_maddr         = maddr_q;
  assign bus.wb_mem_op        = mem_op_q;
  assign bus.wb_gr_we         = gr_we_q;
  assign bus.wb_res_from_mem  = res_from_mem_q;
  assign bus.wb_ertn          = ertn_q;
  assign bus.wb_has_exception = exc_q;
  assign bus.wb_dest          = dest_q;
  assign bus.wb_ecode         = ecode_q;
  assign bus.wb_esubcode      = esub_q;
  assign bus.wb_side          = side_q;
  assign bus.ms_dest          = dest_q;
  assign bus.ms_gr_we         = gr_we_q &
                                ((state_q == StReq) | (state_q == StWait) | (state_q == StDone));
  assign bus.ms_load_pending  = ((state_q == StReq) | (state_q == StWait)) & res_from_mem_q;
endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage: a transaction-level model predicts bus requests and the
// write-back bundle, with directed cases for flush, misalignment and reset.
module tb_mem_stage;
  localparam int unsigned SideW = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mem_stage_if #(.SideW(SideW)) bus ();
  mem_stage #(.SideW(SideW)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  // op: -1 none, 0 LB, 1 LH, 2 LW, 3 LBU, 4 LHU, 5 SB, 6 SH, 7 ST.W
  typedef struct {
    logic [31:0] pc, alu, wdata;
    int          op;
    logic        gr_we, rfm, ertn, exc;
    logic [4:0]  dest;
    logic [5:0]  ecode;
    logic [8:0]  esub;
    logic [63:0] side;
  } ins_t;

  typedef struct {
    bit          req, wr, is_load, ale, exc;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [5:0]  ecode;
    logic [8:0]  esub;
  } exp_t;

  int n_tests = 0;
  int n_fail = 0;

  bit          have_prev = 0;
  ins_t        prev_s;
  exp_t        prev_e;
  logic [31:0] prev_rd;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int op_bytes(input int op);
    case (op)
      0, 3, 5: return 1;
      1, 4, 6: return 2;
      2, 7:    return 4;
      default: return 1;
    endcase
  endfunction

  function automatic logic [7:0] op_onehot(input int op);
    return (op < 0) ? 8'h00 : 8'(1 << op);
  endfunction

  function automatic exp_t model(input ins_t s);
    exp_t e;
    int sz, off;
    sz        = op_bytes(s.op);
    off       = int'(s.alu[1:0]);
    e.is_load = (s.op >= 0) && (s.op <= 4);
    e.ale     = (s.op >= 0) && !s.exc && ((off % sz) != 0);
    e.exc     = s.exc || e.ale;
    e.ecode   = e.ale ? 6'h09 : s.ecode;
    e.esub    = e.ale ? 9'h0 : s.esub;
    e.req     = (s.op >= 0) && !e.exc && !s.ertn;
    e.wr      = s.op >= 5;
    e.size    = (sz == 1) ? 2'd0 : (sz == 2) ? 2'd1 : 2'd2;
    e.wstrb   = 4'h0;
    e.wdata   = 32'h0;
    if (e.wr) begin
      e.wstrb = 4'(((1 << sz) - 1) << off);
      for (int k = 0; k < 4; k++) e.wdata[8*k +: 8] = s.wdata[8*(k % sz) +: 8];
    end
    return e;
  endfunction

  function automatic ins_t rand_ins();
    ins_t s;
    s.op    = int'($urandom_range(0, 8)) - 1;
    s.pc    = $urandom;
    s.alu   = $urandom;
    if ($urandom_range(0, 3) != 0) s.alu = s.alu & ~32'(op_bytes(s.op) - 1);
    s.wdata = $urandom;
    s.rfm   = (s.op >= 0) && (s.op <= 4);
    s.gr_we = (s.op >= 5) ? 1'b0 : 1'($urandom_range(0, 1));
    s.exc   = ($urandom_range(0, 7) == 0);
    s.ertn  = (s.op < 0) && ($urandom_range(0, 7) == 0);
    s.dest  = 5'($urandom);
    s.ecode = 6'($urandom);
    s.esub  = 9'($urandom);
    s.side  = {$urandom, $urandom};
    return s;
  endfunction

  function automatic ins_t mk_ins(input int op, input logic [31:0] alu, input logic [31:0] wd);
    ins_t s;
    s       = rand_ins();
    s.op    = op;
    s.alu   = alu;
    s.wdata = wd;
    s.rfm   = (op >= 0) && (op <= 4);
    s.gr_we = (op >= 5) ? 1'b0 : 1'b1;
    s.exc   = 1'b0;
    s.ertn  = 1'b0;
    return s;
  endfunction

  task automatic drive_ins(input ins_t s);
    bus.ex_pc            = s.pc;
    bus.ex_alu_result    = s.alu;
    bus.ex_wdata         = s.wdata;
    bus.ex_mem_op        = op_onehot(s.op);
    bus.ex_gr_we         = s.gr_we;
    bus.ex_res_from_mem  = s.rfm;
    bus.ex_ertn          = s.ertn;
    bus.ex_has_exception = s.exc;
    bus.ex_dest          = s.dest;
    bus.ex_ecode         = s.ecode;
    bus.ex_esubcode      = s.esub;
    bus.ex_side          = s.side;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_req(input ins_t s, input exp_t e);
    check_eq("req.high", bus.data_req, 1);
    check_eq("req.addr", bus.data_addr, s.alu);
    check_eq("req.wr", bus.data_wr, e.wr);
    check_eq("req.size", bus.data_size, e.size);
    check_eq("req.wstrb", bus.data_wstrb, e.wstrb);
    if (e.wr) check_eq("req.wdata", bus.data_wdata, e.wdata);
  endtask

  task automatic check_wb(input ins_t s, input exp_t e, input logic [31:0] rd);
    check_eq("wb.valid", bus.out_valid, 1);
    check_eq("wb.no_req", bus.data_req, 0);
    check_eq("wb.pc", bus.wb_pc, s.pc);
    check_eq("wb.alu", bus.wb_alu_result, s.alu);
    check_eq("wb.mem_op", bus.wb_mem_op, op_onehot(s.op));
    check_eq("wb.gr_we", bus.wb_gr_we, s.gr_we);
    check_eq("wb.rfm", bus.wb_res_from_mem, s.rfm);
    check_eq("wb.ertn", bus.wb_ertn, s.ertn);
    check_eq("wb.exc", bus.wb_has_exception, e.exc);
    check_eq("wb.dest", bus.wb_dest, s.dest);
    check_eq("wb.ecode", bus.wb_ecode, e.ecode);
    check_eq("wb.esub", bus.wb_esubcode, e.esub);
    check_eq("wb.side", bus.wb_side, s.side);
    check_eq("ms.gr_we", bus.ms_gr_we, s.gr_we);
    if (e.ale) check_eq("wb.maddr", bus.wb_maddr, s.alu);
    if (e.req) check_eq("wb.rdata", bus.wb_rdata, e.is_load ? rd : 32'h0);
  endtask

  // Presents s (stage idle, or holding a finished entry that retires this same cycle) and
  // leaves it in the done state after 'hold' stalled cycles, with out_ready raised again.
  task automatic run_ins(input ins_t s, input int alat, input int dlat, input int hold,
                         input logic [31:0] rd);
    exp_t e;
    e = model(s);
    drive_ins(s);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_eq("in_ready", bus.in_ready, 1);
    if (have_prev) check_wb(prev_s, prev_e, prev_rd);
    next_cycle();
    bus.in_valid = 1'b0;
    drive_ins(rand_ins());
    if (e.req) begin
      for (int k = 0; k <= alat; k++) begin
        bus.data_addr_ok = (k == alat);
        bus.data_data_ok = (k == alat) && ($urandom_range(0, 1) == 1);
        bus.data_rdata   = $urandom;
        @(negedge clk);
        check_req(s, e);
        check_eq("req.pending", bus.ms_load_pending, e.is_load);
        check_eq("req.out_valid", bus.out_valid, 0);
        check_eq("req.in_ready", bus.in_ready, 0);
        check_eq("req.ms_dest", bus.ms_dest, s.dest);
        next_cycle();
      end
      bus.data_addr_ok = 1'b0;
      for (int k = 0; k <= dlat; k++) begin
        bus.data_data_ok = (k == dlat);
        bus.data_rdata   = (k == dlat) ? rd : $urandom;
        @(negedge clk);
        check_eq("wait.req", bus.data_req, 0);
        check_eq("wait.out_valid", bus.out_valid, 0);
        check_eq("wait.pending", bus.ms_load_pending, e.is_load);
        next_cycle();
      end
      bus.data_data_ok = 1'b0;
      bus.data_rdata   = $urandom;
    end
    for (int h = 0; h < hold; h++) begin
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_eq("hold.out_valid", bus.out_valid, 1);
      check_eq("hold.in_ready", bus.in_ready, 0);
      next_cycle();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    have_prev = 1;
    prev_s    = s;
    prev_e    = e;
    prev_rd   = rd;
  endtask

  task automatic retire_idle();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_wb(prev_s, prev_e, prev_rd);
    next_cycle();
    have_prev = 0;
    @(negedge clk);
    check_eq("idle.out_valid", bus.out_valid, 0);
    check_eq("idle.in_ready", bus.in_ready, 1);
    check_eq("idle.ms_gr_we", bus.ms_gr_we, 0);
    next_cycle();
  endtask

  task automatic accept_ins(input ins_t s);
    drive_ins(s);
    bus.in_valid = 1'b1;
    @(negedge clk);
    check_eq("acc.in_ready", bus.in_ready, 1);
    next_cycle();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    ins_t s;
    bus.in_valid     = 1'b0;
    bus.flush        = 1'b0;
    bus.out_ready    = 1'b1;
    bus.data_addr_ok = 1'b0;
    bus.data_data_ok = 1'b0;
    bus.data_rdata   = 32'h0;
    drive_ins(mk_ins(-1, 32'h0, 32'h0));

    #2 rst_n = 1'b0;
    #1;
    check_eq("rst.out_valid", bus.out_valid, 0);
    check_eq("rst.req", bus.data_req, 0);
    check_eq("rst.in_ready", bus.in_ready, 1);
    check_eq("rst.ms_gr_we", bus.ms_gr_we, 0);
    check_eq("rst.wb_pc", bus.wb_pc, 0);
    check_eq("rst.wstrb", bus.data_wstrb, 0);
    check_eq("rst.pending", bus.ms_load_pending, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    next_cycle();

    // ALU op, LW with data_ok three cycles after addr_ok, SB/SH formatting, misaligned LW
    run_ins(mk_ins(-1, 32'h1234, 32'h0), 0, 0, 0, 32'h0);
    retire_idle();
    run_ins(mk_ins(2, 32'h1000, 32'h0), 0, 2, 0, 32'hDEADBEEF);
    retire_idle();
    run_ins(mk_ins(5, 32'h1003, 32'h000000AB), 0, 0, 0, 32'h0);
    run_ins(mk_ins(6, 32'h1002, 32'h0000CDEF), 1, 0, 1, 32'h0);
    retire_idle();
    run_ins(mk_ins(2, 32'h1002, 32'h0), 0, 0, 0, 32'h0);
    retire_idle();

    // Flush in REQ with addr_ok low for two cycles: request persists, response discarded
    accept_ins(mk_ins(2, 32'h2000, 32'h0));
    bus.flush = 1'b1;
    @(negedge clk);
    check_eq("f1.req0", bus.data_req, 1);
    next_cycle();
    bus.flush = 1'b0;
    @(negedge clk);
    check_eq("f1.req1", bus.data_req, 1);
    check_eq("f1.addr", bus.data_addr, 32'h2000);
    check_eq("f1.in_ready1", bus.in_ready, 0);
    next_cycle();
    bus.data_addr_ok = 1'b1;
    @(negedge clk);
    check_eq("f1.req2", bus.data_req, 1);
    next_cycle();
    bus.data_addr_ok = 1'b0;
    @(negedge clk);
    check_eq("f1.req_off", bus.data_req, 0);
    check_eq("f1.in_ready2", bus.in_ready, 0);
    check_eq("f1.pending", bus.ms_load_pending, 0);
    next_cycle();
    bus.data_data_ok = 1'b1;
    bus.data_rdata   = 32'hBAD0BAD0;
    @(negedge clk);
    check_eq("f1.out_valid", bus.out_valid, 0);
    check_eq("f1.in_ready3", bus.in_ready, 0);
    next_cycle();
    bus.data_data_ok = 1'b0;
    @(negedge clk);
    check_eq("f1.in_ready4", bus.in_ready, 1);
    check_eq("f1.out_valid2", bus.out_valid, 0);
    next_cycle();

    // Flush together with data_ok in WAIT goes straight back to idle
    accept_ins(mk_ins(0, 32'h2101, 32'h0));
    bus.data_addr_ok = 1'b1;
    next_cycle();
    bus.data_addr_ok = 1'b0;
    bus.flush        = 1'b1;
    bus.data_data_ok = 1'b1;
    next_cycle();
    bus.flush        = 1'b0;
    bus.data_data_ok = 1'b0;
    @(negedge clk);
    check_eq("f2.in_ready", bus.in_ready, 1);
    check_eq("f2.out_valid", bus.out_valid, 0);
    next_cycle();

    // Flush together with addr_ok in REQ still waits for the response
    accept_ins(mk_ins(7, 32'h2200, 32'h11223344));
    bus.flush        = 1'b1;
    bus.data_addr_ok = 1'b1;
    next_cycle();
    bus.flush        = 1'b0;
    bus.data_addr_ok = 1'b0;
    @(negedge clk);
    check_eq("f3.req", bus.data_req, 0);
    check_eq("f3.in_ready", bus.in_ready, 0);
    next_cycle();
    bus.data_data_ok = 1'b1;
    next_cycle();
    bus.data_data_ok = 1'b0;
    @(negedge clk);
    check_eq("f3.in_ready2", bus.in_ready, 1);
    check_eq("f3.out_valid", bus.out_valid, 0);
    next_cycle();

    // Flush in DONE drops the entry and refuses the offered bundle
    run_ins(mk_ins(-1, 32'h5555, 32'h0), 0, 0, 0, 32'h0);
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    check_eq("f4.out_valid", bus.out_valid, 0);
    next_cycle();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    have_prev    = 0;
    @(negedge clk);
    check_eq("f4.no_accept", bus.out_valid, 0);
    check_eq("f4.in_ready", bus.in_ready, 1);
    next_cycle();

    // Asynchronous reset mid-WAIT, then a normal load
    accept_ins(mk_ins(2, 32'h3000, 32'h0));
    bus.data_addr_ok = 1'b1;
    next_cycle();
    bus.data_addr_ok = 1'b0;
    @(negedge clk);
    check_eq("r.pending_before", bus.ms_load_pending, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("r.req", bus.data_req, 0);
    check_eq("r.out_valid", bus.out_valid, 0);
    check_eq("r.pending", bus.ms_load_pending, 0);
    check_eq("r.wb_alu", bus.wb_alu_result, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    next_cycle();
    run_ins(mk_ins(2, 32'h3004, 32'h0), 1, 1, 0, 32'h12345678);
    retire_idle();

    for (int i = 0; i < 200; i++) begin
      s = rand_ins();
      run_ins(s, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 2)), $urandom);
      if ($urandom_range(0, 1) == 1) retire_idle();
    end
    if (have_prev) retire_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage sitting directly upstream of the write-back stage. It latches one instruction from EX and, for loads and stores, issues a single request on the SRAM-like data bus. It also detects misaligned accesses and waits for the response. It then presents the instruction, including the raw read word, to write-back under a valid/ready handshake. It holds at most one instruction and at most one outstanding bus transaction, and discards in-flight work when write-back signals a flush.

## Interface
- SIDE_W, 64: width of opaque passthrough bundle (csr/mul/div results, res_from_* selects) carried EX→WB untouched.
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  EX bundle valid
- in_ready  out  1  stage can accept EX bundle
- ex_pc, ex_alu_result, ex_wdata  in  32 each  PC, effective address / ALU result, store data
- ex_mem_op  in  8  one-hot: [0]LB [1]LH [2]LW [3]LBU [4]LHU [5]SB [6]SH [7]ST.W
- ex_gr_we, ex_res_from_mem, ex_ertn, ex_has_exception  in  1 each
- ex_dest  in  5;  ex_ecode  in  6;  ex_esubcode  in  9;  ex_side  in  SIDE_W
- flush  in  1  write-back flush (exception or ertn committing)
- data_req, data_wr  out  1;  data_size  out  2 (0 byte, 1 half, 2 word);  data_wstrb  out  4;  data_addr, data_wdata  out  32
- data_addr_ok, data_data_ok  in  1;  data_rdata  in  32
- out_valid  out  1;  out_ready  in  1
- wb_pc, wb_alu_result, wb_rdata, wb_maddr  out  32;  wb_mem_op  out  8;  wb_gr_we, wb_res_from_mem, wb_ertn, wb_has_exception  out  1;  wb_dest  out  5;  wb_ecode  out  6;  wb_esubcode  out  9;  wb_side  out  SIDE_W
- ms_dest  out  5;  ms_gr_we  out  1 (0 when stage empty);  ms_load_pending  out  1  (load held whose data has not yet returned, so ID stalls)

## Operation
- States: IDLE, REQ, WAIT, DONE, DROP_REQ, DROP_WAIT.
- Accept when in_valid & in_ready & ~flush. All ex_* fields are registered.
- Misalignment: LH/LHU/SH with addr[0]≠0, or LW/ST.W with addr[1:0]≠0 → has_exception=1, ecode=6'h09, esubcode=0, maddr=alu_result.
- Next state after accept:
  - DONE if no mem_op bit set, has_exception (incoming or ALE) or ertn; no bus request.
  - REQ otherwise.
- data_req = state∈{REQ, DROP_REQ}. Address, size, wr, wstrb and wdata are held stable while req=1.
- Store formatting:
  - SB: wstrb=1<<addr[1:0], wdata={4{wdata[7:0]}}.
  - SH: wstrb=addr[1]?1100:0011, wdata={2{wdata[15:0]}}.
  - ST.W: wstrb=1111.
  - Loads: wr=0, wstrb=0000.
- REQ --addr_ok--> WAIT. WAIT --data_ok--> DONE, with data_rdata captured into wb_rdata (loads only; stores leave it 0).
- DONE --out_valid & out_ready--> IDLE, or accept a new bundle the same cycle.
- Flush behaviour:
  - IDLE/DONE → IDLE; nothing is accepted that cycle.
  - REQ → DROP_REQ: req is held until addr_ok, so a request is never withdrawn.
  - WAIT → DROP_WAIT.
  - DROP_REQ --addr_ok--> DROP_WAIT --data_ok--> IDLE. The response is discarded.
- The REQ state is never entered on a flush cycle, so no store from a flushed instruction reaches the bus.
- ms_load_pending = state∈{REQ, WAIT} & res_from_mem.

## Timing
- Reset (rst=0, async): state IDLE. out_valid, data_req, in_ready-gating regs, and all wb_*/data_* registers are 0; ms_gr_we=0.
- in_ready = state==IDLE | (state==DONE & out_ready).
- in_ready=0 in REQ, WAIT, DROP_REQ and DROP_WAIT.
- out_valid = state==DONE & ~flush.
- Non-memory / excepting instruction: accepted at cycle N, out_valid at N+1.
- Load or store:
  - Accepted at N; req high from N+1.
  - addr_ok at cycle A≥N+1 → WAIT at A+1.
  - data_ok at D≥A+1 → out_valid at D+1.
- data_ok in the same cycle as addr_ok is a bus protocol violation and is ignored.
- Back-to-back transfer: DONE with out_ready=1 and in_valid=1 replaces the entry in one cycle with no bubble.
- Flush with simultaneous data_ok in WAIT → IDLE; data is dropped.
- Flush with simultaneous addr_ok in REQ → DROP_WAIT.

## Test plan
- ALU op (mem_op=0, alu_result=0x1234) accepted at N → out_valid at N+1, wb_alu_result=0x1234, no data_req.
- LW addr 0x1000, addr_ok same cycle req rises, data_ok 3 cycles later with rdata=0xDEADBEEF → wb_rdata=0xDEADBEEF, out_valid the cycle after data_ok, ms_load_pending high throughout.
- SB addr 0x1003, wdata=0x000000AB → data_wr=1, size=0, wstrb=1000, wdata=0xABABABAB; SH at 0x1002 → wstrb=1100.
- LW addr 0x1002 → no data_req, wb_has_exception=1, wb_ecode=0x09, wb_maddr=0x1002, out_valid at N+1.
- Flush while in REQ with addr_ok held low 2 cycles → req stays high until addr_ok, next data_ok is discarded, out_valid stays 0, in_ready returns 1 after data_ok.
- Assert rst mid-WAIT → data_req and out_valid drop to 0 immediately; after release, a new LW completes normally.
